// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with one holding slot per functional unit
// Result packet type shared by the functional units, the CDB and its consumers.
package cdb_arbiter_pkg;

    typedef struct packed {
        logic [5:0]  phys_rd;
        logic [31:0] phys_rd_val;
        logic [4:0]  rob_index;
        logic        regf_we;
        logic        branch_mismatch;
        logic [31:0] rvfi_pc;
        logic [31:0] rvfi_insn;
    } data_bus_package_t;

endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  data_bus_package_t         fu_pkt [NUM_FU],
    output logic [NUM_FU-1:0]         fu_ready,
    output logic                      cdb_valid,
    output data_bus_package_t         cdb_pkt,
    output logic [$clog2(NUM_FU)-1:0] cdb_src
);

    localparam int SW = $clog2(NUM_FU);

    logic [NUM_FU-1:0] slot_full;
    data_bus_package_t slot_pkt [NUM_FU];
    logic [SW-1:0]     rr_ptr;

    logic [NUM_FU-1:0] grant;
    logic [SW-1:0]     grant_idx;
    logic              grant_any;
    logic [SW-1:0]     next_ptr;

    // Search from rr_ptr upward, wrapping at NUM_FU; the first full slot wins.
    always_comb begin
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr} + (SW+1)'(k);
            if (sum >= (SW+1)'(NUM_FU)) begin
                sum = sum - (SW+1)'(NUM_FU);
            end
            idx = sum[SW-1:0];
            if (!grant_any && slot_full[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    assign next_ptr = (grant_idx == SW'(NUM_FU - 1)) ? '0 : grant_idx + SW'(1);

    // A slot being drained this cycle may be refilled at the same edge.
    assign fu_ready = (rst || flush) ? '0 : (~slot_full | grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
            cdb_src   <= '0;
            cdb_pkt   <= '0;
        end else if (flush) begin
            slot_full <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_pkt <= slot_pkt[grant_idx];
                cdb_src <= grant_idx;
                rr_ptr  <= next_ptr;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_pkt[i]  <= fu_pkt[i];
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with a slot-level reference model
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int SW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      fu_valid;
    data_bus_package_t fu_pkt [N];
    logic [N-1:0]      fu_ready;
    logic              cdb_valid;
    data_bus_package_t cdb_pkt;
    logic [SW-1:0]     cdb_src;

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_pkt    (fu_pkt),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_pkt   (cdb_pkt),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        data_bus_package_t pkt;
        int                src;
    } want_t;

    want_t want_q [$];
    int    seen_src [$];
    int    seen_rob [$];
    int    seen_cyc [$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    // Reference model: which units hold a result, what they hold, where the next search starts.
    bit                m_full [N];
    data_bus_package_t m_pkt  [N];
    int                m_next = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic data_bus_package_t rand_pkt();
        data_bus_package_t p;
        p.phys_rd         = 6'($urandom);
        p.phys_rd_val     = $urandom;
        p.rob_index       = 5'($urandom);
        p.regf_we         = 1'($urandom);
        p.branch_mismatch = 1'($urandom);
        p.rvfi_pc         = $urandom;
        p.rvfi_insn       = $urandom;
        return p;
    endfunction

    // Monitor: every cycle, compare the broadcast against what the model predicted for that edge.
    always begin
        want_t w;
        bit    expect_valid;
        @(posedge clk);
        #1;
        cyc++;
        expect_valid = (want_q.size() > 0);
        chk("cdb_valid", 128'(cdb_valid), 128'(expect_valid));
        if (cdb_valid === 1'b1) begin
            seen_src.push_back(int'(cdb_src));
            seen_rob.push_back(int'(cdb_pkt.rob_index));
            seen_cyc.push_back(cyc);
        end
        if (expect_valid) begin
            w = want_q.pop_front();
            if (cdb_valid === 1'b1) begin
                chk("cdb_pkt", 128'(cdb_pkt), 128'(w.pkt));
                chk("cdb_src", 128'(cdb_src), 128'(w.src));
            end
        end
    end

    // Drive one cycle of stimulus at the negedge, check fu_ready, advance the model across the edge.
    task automatic step(input logic [N-1:0] v, input logic fl, input logic r,
                        input int ou = -1, input data_bus_package_t op = '0);
        int           win;
        logic [N-1:0] want_ready;
        want_t        w;
        fu_valid = v;
        for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
        if (ou >= 0) fu_pkt[ou] = op;
        flush = fl;
        rst   = r;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_next + k) % N;
            if (win < 0 && m_full[j]) win = j;
        end
        for (int i = 0; i < N; i++) want_ready[i] = !r && !fl && (!m_full[i] || i == win);
        chk("fu_ready", 128'(fu_ready), 128'(want_ready));
        if (r) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_next = 0;
        end else if (fl) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
        end else begin
            if (win >= 0) begin
                w.pkt = m_pkt[win];
                w.src = win;
                want_q.push_back(w);
                m_full[win] = 0;
                m_next = (win + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && want_ready[i]) begin
                    m_full[i] = 1;
                    m_pkt[i]  = fu_pkt[i];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
    endtask

    task automatic clear_seen();
        seen_src.delete();
        seen_rob.delete();
        seen_cyc.delete();
    endtask

    initial begin
        data_bus_package_t p;
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        for (int i = 0; i < N; i++) fu_pkt[i] = '0;
        @(negedge clk);
        do_reset();
        chk("reset_cdb_valid", 128'(cdb_valid), 128'(0));
        chk("reset_cdb_src",   128'(cdb_src),   128'(0));
        chk("reset_cdb_pkt",   128'(cdb_pkt),   128'(0));

        // Single request from unit 1, visible two edges after sampling.
        clear_seen();
        p = rand_pkt();
        p.phys_rd     = 6'd7;
        p.phys_rd_val = 32'h0000_00AB;
        step(3'b010, 1'b0, 1'b0, 1, p);
        chk("single_early", 128'(seen_src.size()), 128'(0));
        idle(1);
        chk("single_count", 128'(seen_src.size()), 128'(1));
        chk("single_rd",    128'(cdb_pkt.phys_rd), 128'(7));
        chk("single_val",   128'(cdb_pkt.phys_rd_val), 128'(32'hAB));
        chk("single_src",   128'(cdb_src), 128'(1));
        // Pointer now at 2: units 0 and 2 together must grant 2 first.
        clear_seen();
        step(3'b101, 1'b0, 1'b0);
        idle(3);
        chk("ptr_after_single_n", 128'(seen_src.size()), 128'(2));
        if (seen_src.size() == 2) begin
            chk("ptr_after_single_0", 128'(seen_src[0]), 128'(2));
            chk("ptr_after_single_1", 128'(seen_src[1]), 128'(0));
        end

        // Three-way contention from reset.
        do_reset();
        clear_seen();
        step(3'b111, 1'b0, 1'b0);
        idle(4);
        chk("three_way_n", 128'(seen_src.size()), 128'(3));
        for (int k = 0; k < seen_src.size() && k < 3; k++) begin
            chk("three_way_src", 128'(seen_src[k]), 128'(k));
            chk("three_way_cyc", 128'(seen_cyc[k] - seen_cyc[0]), 128'(k));
        end
        chk("three_way_idle", 128'(cdb_valid), 128'(0));

        // Fairness between two continuously requesting units.
        clear_seen();
        for (int k = 0; k < 8; k++) step(3'b101, 1'b0, 1'b0);
        idle(4);
        chk("fair_n", 128'(seen_src.size() >= 8), 128'(1));
        for (int k = 0; k < seen_src.size() && k < 8; k++)
            chk("fair_src", 128'(seen_src[k]), 128'((k % 2 == 0) ? 0 : 2));

        // Streaming from a lone unit.
        clear_seen();
        for (int k = 0; k < 5; k++) begin
            p = rand_pkt();
            p.rob_index = 5'(k);
            step(3'b100, 1'b0, 1'b0, 2, p);
        end
        idle(3);
        chk("stream_n", 128'(seen_rob.size()), 128'(5));
        for (int k = 0; k < seen_rob.size() && k < 5; k++) begin
            chk("stream_rob", 128'(seen_rob[k]), 128'(k));
            chk("stream_cyc", 128'(seen_cyc[k] - seen_cyc[0]), 128'(k));
        end

        // Flush in the cycle unit 1 is granted.
        do_reset();
        clear_seen();
        step(3'b111, 1'b0, 1'b0);
        idle(1);
        step('0, 1'b1, 1'b0);
        idle(4);
        chk("flush_n", 128'(seen_src.size()), 128'(1));
        step(3'b001, 1'b0, 1'b0);
        idle(3);
        chk("flush_after_n", 128'(seen_src.size()), 128'(2));
        if (seen_src.size() == 2) chk("flush_after_src", 128'(seen_src[1]), 128'(0));

        // Reset while two slots are full and the bus is busy.
        do_reset();
        clear_seen();
        step(3'b111, 1'b0, 1'b0);
        idle(1);
        chk("midrst_busy", 128'(cdb_valid), 128'(1));
        step('0, 1'b0, 1'b1);
        chk("midrst_valid", 128'(cdb_valid), 128'(0));
        chk("midrst_src",   128'(cdb_src),   128'(0));
        idle(5);
        chk("midrst_n", 128'(seen_src.size()), 128'(1));

        // Randomized traffic with occasional flush and reset.
        for (int k = 0; k < 600; k++) begin
            step(N'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end
        idle(N + 2);
        chk("drain_empty", 128'(want_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It accepts completed results from up to `NUM_FU` functional units (ALU, multiplier, load/store, and others), each packaged as a `data_bus_package_t`. It buffers one result per unit, selects one per cycle with round-robin priority, and drives a single registered CDB broadcast to the ROB, the physical register file and the reservation-station wakeup logic. It also discards all in-flight results on a pipeline flush.

## Interface
Parameters:
- `NUM_FU`, default 3: number of requesting functional units; legal range 2..8.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous reset, active-high.
- `flush`  in  1: branch-mismatch or JALR redirect; drops all buffered and outgoing results.
- `fu_valid`  in  `NUM_FU`: unit i presents a result.
- `fu_pkt`  in  `NUM_FU` x `data_bus_package_t`: result packet from unit i.
- `fu_ready`  out  `NUM_FU`: arbiter can accept from unit i this cycle.
- `cdb_valid`  out  1: broadcast valid.
- `cdb_pkt`  out  `data_bus_package_t`: broadcast packet.
- `cdb_src`  out  `$clog2(NUM_FU)`: index of the unit that produced `cdb_pkt`.

## Operation
- Each unit i has a one-entry holding slot with fields `slot_full[i]` and `slot_pkt[i]`.
- Accept: when `fu_valid[i] & fu_ready[i]` at a rising edge, `slot_pkt[i] <= fu_pkt[i]` and `slot_full[i] <= 1`.
- `fu_ready[i] = ~flush & (~slot_full[i] | grant[i])`. A slot granted this cycle can refill at the same edge, which gives one result per cycle from a lone unit.
- Arbitration is combinational over `slot_full`. The search starts at `rr_ptr` and increments modulo `NUM_FU`. The first full slot found wins, giving one-hot `grant`. No full slots gives `grant = 0`.
- On a grant to slot i, at the edge:
  - `cdb_pkt <= slot_pkt[i]`, `cdb_src <= i`, `cdb_valid <= 1`.
  - `slot_full[i]` clears unless it is refilled by a simultaneous accept.
  - `rr_ptr <= (i+1) mod NUM_FU`.
- With no grant: `cdb_valid <= 0`, `rr_ptr` holds, and `cdb_pkt` and `cdb_src` hold their previous values.
- The CDB consumer never stalls, so there is no backpressure on `cdb_*`.
- `cdb_pkt` is copied unmodified from the slot. The arbiter never alters `phys_rd`, `rob_index`, `regf_we`, `branch_mismatch` or the rvfi fields.
- Flush, with precedence over accept and grant:
  - At the edge, all `slot_full <= 0` and `cdb_valid <= 0`.
  - `fu_ready` is 0 during the flush cycle, so no packet is captured.
  - `rr_ptr` holds its value.
- Reset, with precedence over everything:
  - `slot_full <= 0`, `cdb_valid <= 0`, `rr_ptr <= 0`, `cdb_src <= 0`, `cdb_pkt <= '0`.
  - `fu_ready` is combinationally 0 while `rst` is high.
- Reset asserted mid-operation has the same effect: all buffered results are lost, and the first grant afterwards starts the search at unit 0.

## Timing
- Reset values: `cdb_valid=0`, `cdb_src=0`, `cdb_pkt=0`, `fu_ready` all 0 during reset and all 1 in the first cycle after reset (slots empty, no flush).
- Latency: a packet accepted at edge E0 appears on `cdb_*` after edge E1 if it wins at E1. The minimum latency is therefore 2 edges from `fu_valid` sampling to a visible broadcast.
- Worst-case wait in a slot is `NUM_FU` grant cycles, because round-robin guarantees no starvation.
- Throughput is one broadcast per cycle whenever at least one slot is full.
- `cdb_valid` is high for exactly one cycle per granted packet. Consecutive high cycles are distinct packets.
- Simultaneous accept and grant on the same slot: the new packet is stored and the old packet is broadcast. Neither is lost or duplicated.
- Flush coinciding with a grant: the granted packet is not broadcast (`cdb_valid=0` next cycle) and it is dropped.
- Wrap-around: `rr_ptr = NUM_FU-1` with a grant to slot `NUM_FU-1` gives `rr_ptr = 0`.

## Test plan
- Single request: after reset, drive unit 1 valid for one cycle with `phys_rd=7`, `phys_rd_val=0x0000_00AB` → `cdb_valid=1` exactly 2 edges later, `cdb_src=1`, `cdb_pkt` matching the input, `rr_ptr=2`.
- Three-way contention: all three units valid in the same cycle from reset → broadcasts on three consecutive cycles in order src 0, 1, 2, then `cdb_valid=0`.
- Fairness: unit 0 valid continuously and unit 2 valid continuously → grants alternate 0, 2, 0, 2; unit 0 is never granted twice in a row.
- Streaming: only unit 2 valid for 5 cycles with `rob_index` 0..4 → `fu_ready[2]` stays 1 throughout and the CDB shows `rob_index` 0..4 on 5 consecutive cycles.
- Flush: fill all three slots, then assert `flush` in the cycle unit 1 is granted → `cdb_valid=0` from the next cycle on, and all slots are empty. A subsequent unit 0 request broadcasts normally.
- Reset mid-stream: assert `rst` while two slots are full and `cdb_valid=1` → the next cycle shows `cdb_valid=0` and `cdb_src=0`, and no buffered packet is ever broadcast afterwards.
